// File: rtl/regfile_pkg.sv
// +----------------------------------------------------------------------------+
// | regfile_pkg : shared constants and types for the register-file write side  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 9;
  localparam int ADDR_W   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] regidx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

  function automatic logic reg_in_range(input logic [ADDR_W-1:0] idx);
    return (int'(idx) < NUM_REGS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// +----------------------------------------------------------------------------+
// | wb_fifo : in-order write-back queue with per-slot valid bits exported      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  wb_entry_t                    push_entry_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [DEPTH-1:0]             valid_o,
  output wb_entry_t                    entries_o [DEPTH]
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   rptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [DEPTH-1:0]   valid_q;

  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Guards keep the queue consistent even if a caller ignores full/empty.
  assign w_push = push_i && (count_q != CNT_W'(DEPTH));
  assign w_pop  = pop_i  && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (w_push) begin
        valid_q[wptr_q] <= 1'b1;
        wptr_q          <= ptr_next(wptr_q);
      end
      if (w_pop) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= ptr_next(rptr_q);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wptr_q] <= push_entry_i;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_out
      assign entries_o[i] = mem_q[i];
    end
  endgenerate

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// +----------------------------------------------------------------------------+
// | regfile_writeback : arbitrates ALU/load write-backs into the register file |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              wr_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_sel,
  output logic              hazard,
  output logic              err_addr,
  output logic              busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] w_count;
  logic [DEPTH-1:0] w_valid;
  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_match;

  logic             w_not_full;
  wb_src_e          w_src;
  logic             w_fire;
  wb_entry_t        w_req;
  logic             w_addr_ok;
  logic             w_push;
  logic             w_pop;

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q,     err_d;

  // Readiness looks only at the current count, never at a same-cycle drain.
  assign w_not_full = (w_count < CNT_W'(DEPTH));
  assign alu_ready  = w_not_full;
  assign ld_ready   = w_not_full && !alu_valid;

  always_comb begin
    w_src  = alu_valid ? SRC_ALU : SRC_LD;
    w_fire = 1'b0;
    w_req  = '0;
    if (w_src == SRC_ALU) begin
      w_fire = alu_valid && alu_ready;
      w_req  = '{regidx: alu_reg, data: alu_data};
    end else begin
      w_fire = ld_valid && ld_ready;
      w_req  = '{regidx: ld_reg, data: ld_data};
    end
  end

  // Out-of-range indices complete the handshake but are dropped and flagged.
  assign w_addr_ok = reg_in_range(w_req.regidx);
  assign w_push    = w_fire && w_addr_ok;
  assign w_pop     = (w_count != '0) && !wr_hold;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (w_push),
    .push_entry_i (w_req),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .count_o      (w_count),
    .valid_o      (w_valid),
    .entries_o    (w_entries)
  );

  always_comb begin
    wr_en_d   = w_pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q || (w_fire && !w_addr_ok);
    if (w_pop) begin
      wr_addr_d = w_head.regidx;
      wr_data_d = w_head.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
      assign w_match[i] = w_valid[i] && (w_entries[i].regidx == rd_sel);
    end
  endgenerate

  assign hazard   = (wr_en_q && (wr_addr_q == rd_sel)) || (|w_match);
  assign busy     = (w_count != '0) || wr_en_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err_addr = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_writeback : directed stimulus against a queue-based model       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int QDEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              wr_hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_sel;
  logic              hazard;
  logic              err_addr;
  logic              busy;

  regfile_writeback #(.DEPTH(QDEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_reg    (ld_reg),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .wr_hold   (wr_hold),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_sel    (rd_sel),
    .hazard    (hazard),
    .err_addr  (err_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t  m_q[$];
  wr_t  log_q[$];
  logic m_wr_en;
  int   m_wr_addr;
  int   m_wr_data;
  logic m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mdl_accept(input int a, input int d);
    if (a < NUM_REGS) m_q.push_back('{a: a, d: d});
    else m_err = 1'b1;
  endfunction

  // Model: a plain FIFO of pending writes plus the one write being presented.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_wr_en   = 1'b0;
      m_wr_addr = 0;
      m_wr_data = 0;
      m_err     = 1'b0;
    end else begin : mdl_step
      int cnt;
      bit ar;
      bit lr;
      cnt = m_q.size();
      ar  = (cnt < QDEPTH);
      lr  = ar && !alu_valid;
      if (cnt > 0 && !wr_hold) begin
        m_wr_en   = 1'b1;
        m_wr_addr = m_q[0].a;
        m_wr_data = m_q[0].d;
        void'(m_q.pop_front());
      end else begin
        m_wr_en = 1'b0;
      end
      if (alu_valid && ar) mdl_accept(int'(alu_reg), int'(alu_data));
      else if (ld_valid && lr) mdl_accept(int'(ld_reg), int'(ld_data));
    end
  end

  // Per-cycle comparison, well clear of the rising edge.
  always begin
    @(negedge clk);
    #3;
    begin : cmp
      bit h;
      h = m_wr_en && (m_wr_addr == int'(rd_sel));
      foreach (m_q[i]) if (m_q[i].a == int'(rd_sel)) h = 1'b1;
      check("alu_ready", alu_ready, (m_q.size() < QDEPTH));
      check("ld_ready",  ld_ready,  (m_q.size() < QDEPTH) && !alu_valid);
      check("wr_en",     wr_en,     m_wr_en);
      check("wr_addr",   wr_addr,   m_wr_addr);
      check("wr_data",   wr_data,   m_wr_data);
      check("err_addr",  err_addr,  m_err);
      check("busy",      busy,      (m_q.size() != 0) || m_wr_en);
      check("hazard",    hazard,    h);
      if (wr_en === 1'b1) log_q.push_back('{a: int'(wr_addr), d: int'(wr_data)});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic log_expect(input string name, input int idx, input int a, input int d);
    if (log_q.size() > idx) begin
      check({name, "_addr"}, log_q[idx].a, a);
      check({name, "_data"}, log_q[idx].d, d);
    end else begin
      check({name, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_valid = 1'b0; ld_reg = '0; ld_data = '0; wr_hold = 1'b0; rd_sel = '0;
    repeat (2) tick();
    #4;
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    tick();
    reset = 1'b0;

    // Single copy-out, two-cycle latency.
    tick();
    log_q.delete();
    alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'hBEEF;
    tick(); idle(); #4;
    check("t1_lat_wr_en0", wr_en, 0);
    tick(); #4;
    check("t1_wr_en", wr_en, 1);
    check("t1_wr_addr", wr_addr, 3);
    check("t1_wr_data", wr_data, 16'hBEEF);
    tick(); #4;
    check("t1_wr_en_drop", wr_en, 0);
    check("t1_log_size", log_q.size(), 1);

    // ALU and load in the same cycle.
    tick();
    log_q.delete();
    alu_valid = 1'b1; alu_reg = 4'd1; alu_data = 16'h1111;
    ld_valid  = 1'b1; ld_reg  = 4'd2; ld_data  = 16'h2222;
    #4;
    check("t2_ld_ready", ld_ready, 0);
    check("t2_alu_ready", alu_ready, 1);
    tick(); alu_valid = 1'b0; #4;
    check("t2_ld_ready_free", ld_ready, 1);
    tick(); idle();
    repeat (4) tick();
    #4;
    check("t2_log_size", log_q.size(), 2);
    log_expect("t2_w0", 0, 1, 16'h1111);
    log_expect("t2_w1", 1, 2, 16'h2222);

    // Fill with drain held, fifth request refused, then release.
    tick();
    log_q.delete();
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_reg = ADDR_W'(i); alu_data = DATA_W'(16'hA000 + i);
      tick();
    end
    alu_reg = 4'd4; alu_data = 16'hA004;
    #4;
    check("t3_full_alu_ready", alu_ready, 0);
    check("t3_full_ld_ready", ld_ready, 0);
    check("t3_hold_wr_en", wr_en, 0);
    tick(); idle(); wr_hold = 1'b0;
    repeat (7) tick();
    #4;
    check("t3_log_size", log_q.size(), 4);
    for (int i = 0; i < 4; i++) log_expect("t3_w", i, i, 16'hA000 + i);

    // Hazard on a register with pending writes.
    tick();
    log_q.delete();
    wr_hold = 1'b1;
    alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'hA5A5;
    tick(); alu_data = 16'h5A5A;
    tick(); idle(); rd_sel = 4'd5; #4;
    check("t4_hazard_q", hazard, 1);
    rd_sel = 4'd6; #1;
    check("t4_hazard_other", hazard, 0);
    rd_sel = 4'd5;
    tick(); wr_hold = 1'b0; #4;
    check("t4_hazard_rel", hazard, 1);
    tick(); #4;
    check("t4_hazard_w0", hazard, 1);
    tick(); #4;
    check("t4_hazard_w1", hazard, 1);
    tick(); #4;
    check("t4_hazard_clear", hazard, 0);
    check("t4_log_size", log_q.size(), 2);
    log_expect("t4_w0", 0, 5, 16'hA5A5);
    log_expect("t4_w1", 1, 5, 16'h5A5A);

    // Out-of-range index: sticky error, nothing written, next request fine.
    tick();
    log_q.delete();
    rd_sel = 4'd0;
    alu_valid = 1'b1; alu_reg = 4'd12; alu_data = 16'hDEAD;
    #4;
    check("t5_err_pre", err_addr, 0);
    tick(); idle();
    ld_valid = 1'b1; ld_reg = 4'd7; ld_data = 16'h7777;
    #4;
    check("t5_err_set", err_addr, 1);
    check("t5_busy", busy, 0);
    tick(); idle();
    repeat (3) tick();
    #4;
    check("t5_err_sticky", err_addr, 1);
    check("t5_log_size", log_q.size(), 1);
    log_expect("t5_w0", 0, 7, 16'h7777);

    // Reset mid-operation.
    tick();
    wr_hold = 1'b1;
    alu_valid = 1'b1; alu_reg = 4'd6; alu_data = 16'hC006;
    tick(); alu_reg = 4'd7; alu_data = 16'hC007;
    tick(); alu_reg = 4'd8; alu_data = 16'hC008;
    tick(); idle(); wr_hold = 1'b0;
    tick(); #1;
    check("t6_wr_en_before", wr_en, 1);
    log_q.delete();
    reset = 1'b1; #1;
    check("t6_rst_wr_en", wr_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err_addr, 0);
    tick(); tick();
    reset = 1'b0;
    repeat (6) tick();
    #4;
    check("t6_no_writes", log_q.size(), 0);
    check("t6_busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
